// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and the IF/ID register.
// Define FETCH_RAS_EN to build in a circular return-address stack for RET targets.
module fetch_unit #(
  parameter int unsigned   AW        = 16,
  parameter int unsigned   IW        = 16,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [IW-1:0] NOP_WORD  = IW'(16'hF000),
  parameter int unsigned   RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          killF,
  input  logic [1:0]    PCSrc,
  input  logic          PCsrcJType,
  input  logic          RRSrc,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] for_target,
  input  logic [AW-1:0] jump_target,
  input  logic [AW-1:0] reg_target,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          imem_valid,
  output logic [IW-1:0] if_id_instr,
  output logic [AW-1:0] if_id_pc,
  output logic [AW-1:0] if_id_pc_plus1,
  output logic          if_id_valid,
  output logic          ras_overflow,
  output logic          ras_underflow
);

  logic [AW-1:0] pc_p0;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] ret_target;
  logic [IW-1:0] instr_p1;
  logic [AW-1:0] pc_p1;
  logic [AW-1:0] pc1_p1;
  logic          vld_p1;

`ifdef FETCH_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_wp;
  logic [PW-1:0] ras_top;
  logic [CW-1:0] ras_cnt;
  logic          ras_push;
  logic          ras_pop;
  logic          ovf_q;
  logic          unf_q;

  // ras_wp is the next slot to write; the newest entry sits just below it
  assign ras_top  = (ras_wp == '0) ? PW'(RAS_DEPTH - 1) : ras_wp - PW'(1);
  assign ras_pop  = !stall && (PCSrc == 2'b11) && PCsrcJType;
  assign ras_push = !stall && RRSrc && !ras_pop;
  assign ret_target = (ras_cnt != '0) ? ras_mem[ras_top] : reg_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_wp  <= '0;
      ras_cnt <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (ras_pop) begin
      if (ras_cnt == '0) begin
        unf_q <= 1'b1;
      end else begin
        ras_wp  <= ras_top;
        ras_cnt <= ras_cnt - CW'(1);
      end
    end else if (ras_push) begin
      ras_wp <= (ras_wp == PW'(RAS_DEPTH - 1)) ? '0 : ras_wp + PW'(1);
      if (ras_cnt == CW'(RAS_DEPTH)) begin
        ovf_q <= 1'b1;
      end else begin
        ras_cnt <= ras_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_wp] <= pc1_p1;
    end
  end

  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
`else
  logic unused_ras;

  assign unused_ras    = ^{RRSrc, 32'(RAS_DEPTH)};
  assign ret_target    = reg_target;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    pc_nxt = pc_p0;
    if (!stall) begin
      case (PCSrc)
        2'b01:   pc_nxt = branch_target;
        2'b10:   pc_nxt = for_target;
        2'b11:   pc_nxt = PCsrcJType ? ret_target : jump_target;
        default: if (imem_valid) pc_nxt = pc_p0 + AW'(1);
      endcase
    end
  end

  // Stage p0: program counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= pc_nxt;
    end
  end

  assign imem_addr = pc_p0;

  // Stage p1: IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1 <= NOP_WORD;
      pc_p1    <= '0;
      pc1_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (!stall) begin
      if (killF || !imem_valid) begin
        instr_p1 <= NOP_WORD;
        pc_p1    <= '0;
        pc1_p1   <= '0;
        vld_p1   <= 1'b0;
      end else begin
        instr_p1 <= imem_rdata;
        pc_p1    <= pc_p0;
        pc1_p1   <= pc_p0 + AW'(1);
        vld_p1   <= 1'b1;
      end
    end
  end

  assign if_id_instr    = instr_p1;
  assign if_id_pc       = pc_p1;
  assign if_id_pc_plus1 = pc1_p1;
  assign if_id_valid    = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed sequences push expected IF/ID words, a monitor checks them.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        killF;
  logic [1:0]  PCSrc;
  logic        PCsrcJType;
  logic        RRSrc;
  logic [15:0] branch_target;
  logic [15:0] for_target;
  logic [15:0] jump_target;
  logic [15:0] reg_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic        ras_overflow;
  logic        ras_underflow;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic held_m;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .killF(killF), .PCSrc(PCSrc),
    .PCsrcJType(PCsrcJType), .RRSrc(RRSrc), .branch_target(branch_target),
    .for_target(for_target), .jump_target(jump_target), .reg_target(reg_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_valid(if_id_valid), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  // Instruction memory contents: word at address a is {4'h1, a[11:0]}
  function automatic logic [15:0] word(input logic [15:0] a);
    return {4'h1, a[11:0]};
  endfunction

  assign imem_rdata = word(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] pc1);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc1   = pc1;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 1'b0; killF = 1'b0; PCSrc = 2'b00; PCsrcJType = 1'b0; RRSrc = 1'b0;
  endtask

  // Monitor: every freshly loaded valid IF/ID word must match the head of the queue
  always @(posedge clk) begin
    held_m = stall;
    #2;
    if (if_id_valid && !held_m) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got instr %h pc %h, expected no output", if_id_instr, if_id_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_instr", if_id_instr, e.instr);
        chk("sb_pc", if_id_pc, e.pc);
        chk("sb_pc_plus1", if_id_pc_plus1, e.pc1);
      end
    end
  end

  initial begin
    reset = 1'b1; imem_valid = 1'b1;
    branch_target = '0; for_target = '0; jump_target = '0; reg_target = '0;
    clear_ctl();
    tick(); tick();
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", if_id_instr, 16'hF000);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_pc", if_id_pc, 16'h0000);
    chk("rst_pc1", if_id_pc_plus1, 16'h0000);
    chk("rst_flags", {ras_overflow, ras_underflow}, 2'b00);
    reset = 1'b0;

    // Sequential fetch 0..3
    for (int i = 0; i < 4; i++) begin
      chk("step_addr", imem_addr, 32'(i));
      push(word(16'(i)), 16'(i), 16'(i + 1));
      tick();
    end
    push(16'h1004, 16'h0004, 16'h0005);
    tick();
    chk("pre_branch_addr", imem_addr, 16'h0005);

    // Branch with flush from PC 5
    PCSrc = 2'b01; killF = 1'b1; branch_target = 16'h0040;
    tick();
    clear_ctl();
    chk("branch_addr", imem_addr, 16'h0040);
    chk("branch_bubble_valid", if_id_valid, 1'b0);
    chk("branch_bubble_instr", if_id_instr, 16'hF000);
    push(16'h1040, 16'h0040, 16'h0041);
    tick();

    // Stall beats a jump redirect; the jump lands once stall drops
    stall = 1'b1; PCSrc = 2'b11; PCsrcJType = 1'b0; jump_target = 16'h0080;
    tick();
    chk("stall_addr", imem_addr, 16'h0041);
    chk("stall_instr", if_id_instr, 16'h1040);
    chk("stall_pc", if_id_pc, 16'h0040);
    chk("stall_valid", if_id_valid, 1'b1);
    stall = 1'b0; killF = 1'b1;
    tick();
    clear_ctl();
    chk("jump_addr", imem_addr, 16'h0080);
    chk("jump_bubble_valid", if_id_valid, 1'b0);
    push(16'h1080, 16'h0080, 16'h0081);
    tick();

    // Memory wait for two cycles at PC 7
    PCSrc = 2'b01; killF = 1'b1; branch_target = 16'h0007;
    tick();
    clear_ctl();
    imem_valid = 1'b0;
    tick();
    chk("wait1_addr", imem_addr, 16'h0007);
    chk("wait1_valid", if_id_valid, 1'b0);
    tick();
    chk("wait2_addr", imem_addr, 16'h0007);
    chk("wait2_valid", if_id_valid, 1'b0);
    imem_valid = 1'b1;
    push(16'h1007, 16'h0007, 16'h0008);
    tick();
    chk("wait_resume_addr", imem_addr, 16'h0008);
    push(16'h1008, 16'h0008, 16'h0009);
    tick();

    // PC wrap at 16'hFFFF
    PCSrc = 2'b01; killF = 1'b1; branch_target = 16'hFFFF;
    tick();
    clear_ctl();
    chk("wrap_pre_addr", imem_addr, 16'hFFFF);
    push(16'h1FFF, 16'hFFFF, 16'h0000);
    tick();
    chk("wrap_addr", imem_addr, 16'h0000);
    push(16'h1000, 16'h0000, 16'h0001);
    tick();

    // Stall beats killF
    stall = 1'b1; killF = 1'b1;
    tick();
    chk("stall_kill_addr", imem_addr, 16'h0001);
    chk("stall_kill_valid", if_id_valid, 1'b1);
    chk("stall_kill_instr", if_id_instr, 16'h1000);
    clear_ctl();
    push(16'h1001, 16'h0001, 16'h0002);
    tick();

    // killF with no redirect: flush, PC still advances
    killF = 1'b1;
    tick();
    clear_ctl();
    chk("kill_only_addr", imem_addr, 16'h0003);
    chk("kill_only_valid", if_id_valid, 1'b0);

    // Reset overrides a stall and a pending redirect
    stall = 1'b1; PCSrc = 2'b01; branch_target = 16'h0055; reset = 1'b1;
    tick();
    chk("midrst_addr", imem_addr, 16'h0000);
    chk("midrst_valid", if_id_valid, 1'b0);
    chk("midrst_instr", if_id_instr, 16'hF000);
    chk("midrst_pc1", if_id_pc_plus1, 16'h0000);
    reset = 1'b0;
    clear_ctl();

`ifdef FETCH_RAS_EN
    PCSrc = 2'b01; killF = 1'b1; branch_target = 16'h0010;
    tick();
    for (int i = 1; i <= 5; i++) begin
      clear_ctl();
      push(word(16'(i * 16)), 16'(i * 16), 16'(i * 16 + 1));
      tick();
      RRSrc = 1'b1; PCSrc = 2'b11; PCsrcJType = 1'b0; killF = 1'b1;
      jump_target = 16'(i * 16 + 16);
      tick();
      if (i == 4) chk("ras_ovf_at4", ras_overflow, 1'b0);
      if (i == 5) chk("ras_ovf_at5", ras_overflow, 1'b1);
    end
    begin
      logic [15:0] ret_exp [5];
      ret_exp = '{16'h0051, 16'h0041, 16'h0031, 16'h0021, 16'h0099};
      clear_ctl();
      PCSrc = 2'b11; PCsrcJType = 1'b1; killF = 1'b1; reg_target = 16'h0099;
      for (int j = 0; j < 5; j++) begin
        tick();
        chk("ras_ret_addr", imem_addr, ret_exp[j]);
        chk("ras_unf", ras_underflow, (j == 4) ? 1'b1 : 1'b0);
      end
    end
`else
    RRSrc = 1'b1; PCSrc = 2'b11; PCsrcJType = 1'b1; killF = 1'b1; reg_target = 16'h0099;
    tick();
    chk("ret_reg_addr", imem_addr, 16'h0099);
    chk("noras_flags", {ras_overflow, ras_underflow}, 2'b00);
`endif

    clear_ctl();
    imem_valid = 1'b0;
    tick(); tick();
    chk("sb_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined core.
- Consumes the redirect, flush and stall controls that the ID-stage controller and hazard logic produce: stall, killF, PCSrc, PCsrcJType, RRSrc.
- Owns the PC, drives the instruction-memory address, and supplies the instruction and PC values that ID decodes. It is the producer end of the ID-stage decode interface.

Parameters:
- AW, 16, PC / instruction-address width (word addressed)
- IW, 16, instruction width
- RESET_PC, 0, PC value after reset
- NOP_WORD, 16'hF000, instruction word injected as a bubble (NOOP opcode in [15:12])
- RAS_DEPTH, 4, return-address-stack entries (used only with RAS_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID (load-use hazard)
- killF  in  1  flush the instruction currently being fetched
- PCSrc  in  2  00 = PC+1, 01 = branch_target, 10 = for_target, 11 = jump/ret
- PCsrcJType  in  1  when PCSrc = 11: 0 = jump_target, 1 = return (register/RAS)
- RRSrc  in  1  ID instruction is CALL
- branch_target  in  AW  BEQ/BNE target from ID
- for_target  in  AW  FOR loop target from ID
- jump_target  in  AW  JMP/CALL target from ID
- reg_target  in  AW  RET target read from register file
- imem_addr  out  AW  instruction memory address (= PC register)
- imem_rdata  in  IW  instruction word for imem_addr
- imem_valid  in  1  imem_rdata valid this cycle
- if_id_instr  out  IW  instruction presented to ID
- if_id_pc  out  AW  PC of if_id_instr
- if_id_pc_plus1  out  AW  if_id_pc + 1, used as the CALL return address
- if_id_valid  out  1  if_id_instr is a real fetched instruction
- ras_overflow  out  1  sticky: push onto full RAS
- ras_underflow  out  1  sticky: pop from empty RAS

Behaviour:
- Reset (synchronous, one cycle) sets:
  - PC = RESET_PC
  - if_id_instr = NOP_WORD, if_id_pc = 0, if_id_pc_plus1 = 0, if_id_valid = 0
  - RAS emptied; ras_overflow = 0, ras_underflow = 0
- imem_addr is the PC register output, combinational with no added delay.
- Latency: a word accepted at edge n appears on if_id_* after edge n (one cycle).
- Next-PC priority, evaluated at each edge:
  1. reset
  2. stall: PC holds; any redirect is ignored this cycle, and ID re-presents the same instruction next cycle.
  3. PCSrc != 00: PC = selected target:
     - 01 = branch_target
     - 10 = for_target
     - 11 with PCsrcJType = 0 = jump_target
     - 11 with PCsrcJType = 1 = return target (reg_target, or RAS top with RAS_EN)
  4. imem_valid = 0: PC holds (memory wait).
  5. Otherwise PC = PC + 1, modulo 2^AW (16'hFFFF wraps to 16'h0000).
- IF/ID register, same priority order:
  - stall: hold all if_id_* outputs.
  - killF: if_id_instr = NOP_WORD, if_id_valid = 0; PC fields are don't-care but driven 0.
  - imem_valid = 0: bubble, same as killF.
  - Otherwise load imem_rdata, PC and PC + 1; if_id_valid = 1.
- killF while PCSrc = 00 (e.g. RET with no other redirect source): flush is still applied; the PC follows the priority list above.
- Stall wins over killF and over redirect on the same edge.
- An imem_valid drop mid-stream only inserts bubbles; no word is lost or duplicated.
- Reset asserted mid-operation overrides everything, including a pending redirect or a stall.
- Without RAS_EN, ras_overflow and ras_underflow are tied to 0.

Optional Feature:
- Macro: FETCH_RAS_EN.
- With the macro defined, a RAS_DEPTH-entry return-address stack is built in:
  - Push: CALL committed (RRSrc = 1 and stall = 0); pushes if_id_pc_plus1.
  - Pop: RET committed (PCSrc = 11, PCsrcJType = 1, stall = 0); the popped value is the redirect target.
  - Push when full: the oldest entry is overwritten (circular buffer), depth stays RAS_DEPTH, ras_overflow is set.
  - Pop when empty: target = reg_target, ras_underflow is set.
  - Push and pop never occur on the same edge.
  - Both flags are sticky until reset.
- Without the macro: RET always uses reg_target, no stack storage exists, and both flags are 0.

Test Plan:
- Reset then run with imem_valid = 1: imem_addr steps 0, 1, 2, 3; the word at address 2 appears on if_id_instr one cycle later with if_id_pc = 2, if_id_pc_plus1 = 3, if_id_valid = 1.
- PC = 5 with PCSrc = 01, killF = 1, branch_target = 16'h0040: next imem_addr = 0x40; IF/ID holds NOP_WORD with valid = 0 for one cycle, and the word at 0x40 follows.
- stall = 1 together with PCSrc = 11, PCsrcJType = 0, jump_target = 0x80: PC and IF/ID hold and no redirect occurs; a redirect asserted the following cycle without stall takes effect.
- imem_valid low for 2 cycles at PC = 7: imem_addr stays 7, two bubbles enter IF/ID, then word 7 followed by word 8 with no duplicate.
- PC = 16'hFFFF, no redirect: next imem_addr = 0; if_id_pc_plus1 for that word = 0.
- FETCH_RAS_EN, RAS_DEPTH = 4: five CALLs from PCs 0x10, 0x20, 0x30, 0x40, 0x50 set ras_overflow = 1. Five RETs with reg_target = 0x99 go to 0x51, 0x41, 0x31, 0x21, then 0x99, and ras_underflow = 1.
